// File: rtl/fifo_rd_pkg.sv
// Shared types for the frame FIFO read-side sequencer.
// State encoding, FIFO word layout and eop bit position.
package fifo_rd_pkg;

  localparam int PKG_DATA_W = 8;
  localparam int EOP_BIT    = PKG_DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP
  } rd_state_e;

  typedef struct packed {
    logic                  eop;
    logic [PKG_DATA_W-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// 2-entry skid buffer absorbing the 1-cycle FIFO read latency.
// Ports: empty flag in, rd_en out, read word in, pop in, head out.
module fifo_rd_skid #(
  parameter int W = 9
) (
  input  logic         i_clk_rd,
  input  logic         i_rst_n,
  input  logic         i_fifo_empty,
  output logic         o_rd_en,
  input  logic [W-1:0] i_rd_data,
  input  logic         i_pop,
  output logic         o_head_vld,
  output logic [W-1:0] o_head
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [1:0]   occ;
  logic         infl;

  // Slots already claimed (stored + returning) bound new reads.
  assign o_rd_en = !i_fifo_empty &&
                   (({1'b0, occ} + {2'b00, infl}) < 3'd2);

  assign o_head_vld = (occ != 2'd0);
  assign o_head     = e0;

  always_ff @(posedge i_clk_rd or negedge i_rst_n) begin
    if (!i_rst_n) begin
      e0   <= '0;
      e1   <= '0;
      occ  <= 2'd0;
      infl <= 1'b0;
    end else begin
      infl <= o_rd_en;
      unique case ({infl, i_pop})
        2'b10: begin
          if (occ == 2'd0) e0 <= i_rd_data;
          else             e1 <= i_rd_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        // Only reachable at occupancy 1: head replaced in place.
        2'b11: e0 <= i_rd_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_frame_ctrl.sv
// Read-side frame sequencer: FIFO reads, byte stream, IFG, length.
// Ports: FIFO empty/rd_en/rd_data, tdata/tvalid/tlast/tready, status.
module fifo_rd_frame_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W        = PKG_DATA_W,
  parameter int LEN_W         = 11,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int IFG_CYCLES    = 12
) (
  input  logic              i_clk_rd,
  input  logic              i_rst_n,
  input  logic              i_fifo_empty,
  output logic              o_fifo_rd_en,
  input  logic [DATA_W:0]   i_fifo_rd_data,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tvalid,
  output logic              o_tlast,
  input  logic              i_tready,
  output logic              o_frame_done,
  output logic [LEN_W-1:0]  o_frame_len,
  output logic              o_len_err,
  output logic              o_busy
);

  localparam int GAP_W = $clog2(IFG_CYCLES) + 1;
  localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(IFG_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_SAT = '1;
  localparam logic [LEN_W-1:0] ERR_PRE = LEN_W'(MAX_FRAME_LEN);
  localparam logic [LEN_W-1:0] ERR_AT  = LEN_W'(MAX_FRAME_LEN + 1);

  rd_state_e         state;
  rd_state_e         state_nxt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cnt_inc;
  logic              head_vld;
  logic [DATA_W:0]   head;
  logic              accept;
  logic              beat_last;

  fifo_rd_skid #(.W(DATA_W + 1)) u_skid (
    .i_clk_rd     (i_clk_rd),
    .i_rst_n      (i_rst_n),
    .i_fifo_empty (i_fifo_empty),
    .o_rd_en      (o_fifo_rd_en),
    .i_rd_data    (i_fifo_rd_data),
    .i_pop        (accept),
    .o_head_vld   (head_vld),
    .o_head       (head)
  );

  assign o_tvalid  = head_vld && (state != GAP);
  assign o_tdata   = head[DATA_W-1:0];
  assign o_tlast   = head[DATA_W];
  assign o_busy    = (state != IDLE);
  assign accept    = o_tvalid && i_tready;
  assign beat_last = accept && head[DATA_W];
  assign cnt_inc   = (cnt == LEN_SAT) ? cnt : cnt + LEN_W'(1);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (beat_last)     state_nxt = GAP;
        else if (head_vld) state_nxt = STREAM;
      end
      STREAM: if (beat_last)        state_nxt = GAP;
      GAP:    if (gap_cnt == '0)    state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_rd or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state != GAP && state_nxt == GAP)
        gap_cnt <= GAP_LD;
      else if (state == GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  always_ff @(posedge i_clk_rd or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt          <= '0;
      o_frame_len  <= '0;
      o_frame_done <= 1'b0;
      o_len_err    <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_len_err    <= 1'b0;
      if (accept) begin
        cnt       <= beat_last ? '0 : cnt_inc;
        // Fires only on the crossing beat, once per frame.
        o_len_err <= (cnt == ERR_PRE) && (cnt_inc == ERR_AT);
        if (beat_last) begin
          o_frame_len  <= cnt_inc;
          o_frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_frame_ctrl.sv
// Scoreboard bench for fifo_rd_frame_ctrl with a FIFO model.
// Directed frames; a negedge monitor pops expected beats/lengths.
module tb_fifo_rd_frame_ctrl;
  import fifo_rd_pkg::*;

  localparam int DW   = 8;
  localparam int LW   = 11;
  localparam int MAXL = 1518;
  localparam int IFG  = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty;
  logic          rd_en;
  logic [DW:0]   rd_data = '0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready = 1'b0;
  logic          done;
  logic [LW-1:0] flen;
  logic          len_err;
  logic          busy;

  always #5 clk = ~clk;

  fifo_rd_frame_ctrl #(
    .DATA_W(DW), .LEN_W(LW),
    .MAX_FRAME_LEN(MAXL), .IFG_CYCLES(IFG)
  ) dut (
    .i_clk_rd       (clk),
    .i_rst_n        (rst_n),
    .i_fifo_empty   (fifo_empty),
    .o_fifo_rd_en   (rd_en),
    .i_fifo_rd_data (rd_data),
    .o_tdata        (tdata),
    .o_tvalid       (tvalid),
    .o_tlast        (tlast),
    .i_tready       (tready),
    .o_frame_done   (done),
    .o_frame_len    (flen),
    .o_len_err      (len_err),
    .o_busy         (busy)
  );

  int pass_n = 0;
  int total_n = 0;

  function automatic void chk(string nm, int got, int exp);
    total_n++;
    if (got == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endfunction

  // FIFO model
  fifo_word_t fq[$];
  int         fq_n = 0;
  logic       force_empty = 1'b0;
  assign fifo_empty = force_empty || (fq_n == 0);

  always @(posedge clk) begin
    if (rst_n && rd_en && !fifo_empty) rd_data <= fq.pop_front();
    fq_n <= fq.size();
  end

  // scoreboard queues
  fifo_word_t exp_q[$];
  int len_q[$];
  int err_q[$];

  int   acc_total = 0;
  int   fbeats = 0;
  int   prev_idx = 0;
  int   outst = 0;
  int   max_out = 0;
  int   spurious = 0;
  int   unstable = 0;
  logic stall_pend = 1'b0;
  logic [DW-1:0] st_d;
  logic st_l;
  logic gap_chk = 1'b0;
  logic gap_run = 1'b0;
  int   gap_cnt = 0;
  int   gaps_measured = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      fbeats = 0; prev_idx = 0; outst = 0;
      stall_pend = 1'b0; gap_run = 1'b0;
    end else begin
      fifo_word_t e;
      if (rd_en && fifo_empty) spurious++;
      if (stall_pend && (!tvalid || tdata != st_d || tlast != st_l))
        unstable++;
      stall_pend = tvalid && !tready;
      st_d = tdata;
      st_l = tlast;
      outst = outst + int'(rd_en && !fifo_empty) - int'(tvalid && tready);
      if (outst > max_out) max_out = outst;
      if (done) begin
        if (len_q.size() == 0) chk("frame_done_unexpected", 1, 0);
        else chk("frame_len", int'(flen), len_q.pop_front());
      end
      if (len_err) begin
        if (err_q.size() == 0) chk("len_err_unexpected", 1, 0);
        else chk("len_err_beat", prev_idx, err_q.pop_front());
      end
      if (gap_run) begin
        if (!tvalid) gap_cnt++;
        else begin
          chk("ifg_cycles", gap_cnt, IFG);
          gaps_measured++;
          gap_run = 1'b0;
          gap_chk = 1'b0;
        end
      end
      prev_idx = 0;
      if (tvalid && tready) begin
        acc_total++;
        fbeats++;
        prev_idx = fbeats;
        if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat", int'({tlast, tdata}), int'(e));
        end
        if (tlast) begin
          fbeats = 0;
          if (gap_chk) begin gap_run = 1'b1; gap_cnt = 0; end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push_word(input logic [7:0] d, input logic eop,
                           input logic expect_beat);
    fifo_word_t w;
    w.eop = eop;
    w.data = d;
    fq.push_back(w);
    fq_n = fq.size();
    if (expect_beat) exp_q.push_back(w);
  endtask

  task automatic wait_drain(input string nm, input int budget,
                            input logic tog);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && len_q.size() == 0 && !busy && !tvalid)
        break;
      if (tog) tready = ~tready;
      step(1);
    end
    chk({nm, "_beats_left"}, exp_q.size(), 0);
    chk({nm, "_lens_left"}, len_q.size(), 0);
    chk({nm, "_errs_left"}, err_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int target;
    step(3);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_len", int'(flen), 0);
    chk("rst_tdata", int'(tdata), 0);
    rst_n = 1'b1;
    step(2);
    chk("idle_rd_en", rd_en, 0);
    chk("idle_len_err", len_err, 0);

    // 1: 4-byte frame, latency and gap length
    tready = 1'b1;
    push_word(8'h11, 0, 1); push_word(8'h22, 0, 1);
    push_word(8'h33, 0, 1); push_word(8'h44, 1, 1);
    len_q.push_back(4);
    @(negedge clk);
    chk("t1_rd_en_first", rd_en, 1);
    chk("t1_tvalid_c0", tvalid, 0);
    @(negedge clk);
    chk("t1_tvalid_c1", tvalid, 0);
    @(negedge clk);
    chk("t1_tvalid_c2", tvalid, 1);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("t1_done_seen", done, 1);
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    chk("t1_gap_busy", n, IFG);
    step(1);
    wait_drain("t1", 100, 0);

    // 2: same frame, tready toggling
    tready = 1'b0;
    push_word(8'h11, 0, 1); push_word(8'h22, 0, 1);
    push_word(8'h33, 0, 1); push_word(8'h44, 1, 1);
    len_q.push_back(4);
    wait_drain("t2", 200, 1);
    tready = 1'b1;

    // 3: back-to-back preloaded frames
    gap_chk = 1'b1;
    push_word(8'hAA, 1, 1);
    push_word(8'hBB, 0, 1); push_word(8'hCC, 1, 1);
    len_q.push_back(1); len_q.push_back(2);
    wait_drain("t3", 200, 0);
    chk("t3_gap_measured", gaps_measured, 1);
    gap_chk = 1'b0;

    // 4: oversize frame
    for (int i = 0; i < 1520; i++)
      push_word(8'(i), (i == 1519), 1);
    err_q.push_back(1519);
    len_q.push_back(1520);
    wait_drain("t4", 4000, 0);

    // 5: empty mid-frame after byte 3 of 6
    target = acc_total + 3;
    push_word(8'h01, 0, 1); push_word(8'h02, 0, 1);
    push_word(8'h03, 0, 1);
    for (int i = 0; i < 50 && acc_total < target; i++) step(1);
    chk("t5_three_accepted", acc_total, target);
    force_empty = 1'b1;
    push_word(8'h04, 0, 1); push_word(8'h05, 0, 1);
    push_word(8'h06, 1, 1);
    len_q.push_back(6);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      n += int'(tvalid) + int'(rd_en);
    end
    chk("t5_starved_quiet", n, 0);
    chk("t5_fifo_untouched", fq.size(), 3);
    force_empty = 1'b0;
    wait_drain("t5", 200, 0);

    // 6: reset with two words buffered mid-frame
    tready = 1'b0;
    push_word(8'h61, 0, 1);
    push_word(8'h62, 0, 0); push_word(8'h63, 0, 0);
    push_word(8'h64, 0, 0); push_word(8'h65, 1, 0);
    step(4);
    tready = 1'b1;
    step(1);
    tready = 1'b0;
    step(3);
    chk("t6_busy_pre", busy, 1);
    chk("t6_tvalid_pre", tvalid, 1);
    rst_n = 1'b0;
    fq.delete();
    fq_n = 0;
    #1;
    n = int'(tvalid) + int'(tlast) + int'(tdata != 0) + int'(busy) +
        int'(done) + int'(len_err) + int'(flen != 0);
    chk("t6_outputs_zero", n, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    tready = 1'b1;
    push_word(8'h71, 0, 1); push_word(8'h72, 0, 1);
    push_word(8'h73, 1, 1);
    len_q.push_back(3);
    wait_drain("t6", 200, 0);

    chk("no_rd_when_empty", spurious, 0);
    chk("stall_data_stable", unstable, 0);
    chk("max_outstanding_le2", int'(max_out <= 2), 1);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
